rca_seq_ctrl: RTL and testbench
===============================

# rca_seq_ctrl

Multi-nibble adder/subtractor controller that reuses the existing 4-bit ripple-carry adder `RCA`, one nibble per clock. It latches two WIDTH-bit operands on `start` and feeds nibble 0 through nibble N-1 through the single `RCA` instance, registering the carry between cycles. It then presents a registered sum, carry-out and signed overflow with a one-cycle `done` pulse. It sits between the lab's operand registers and the display/checking logic, so the 4-bit `RCA` datapath scales to wide words without extra adder hardware.

## Interface
- `WIDTH`, default 16: operand/result width; must be a multiple of 4; N = WIDTH/4 nibble steps.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `sub`  in  1  0 = A+B+cin, 1 = A−B (two's complement); sampled with `start`.
- `a`  in  WIDTH  operand A, two's complement; sampled with `start`.
- `b`  in  WIDTH  operand B, two's complement; sampled with `start`.
- `cin`  in  1  carry-in for add; ignored when `sub`=1; sampled with `start`.
- `busy`  out  1  high while nibbles are being processed.
- `done`  out  1  one-cycle pulse when the result is valid.
- `sum`  out  WIDTH  result, registered, held until next completion.
- `cout`  out  1  carry out of MSB nibble (for `sub`=1: 1 = no borrow).
- `ovf`  out  1  signed overflow of the WIDTH-bit operation.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On `start`=1, latch opA=`a`, opB=`sub`?~`b`:`b`, carry=`sub`?1:`cin`, idx=0 → RUN.
  - `start`=0 → stay.
- RUN:
  - `RCA` inputs: A=opA[4·idx+:4], B=opB[4·idx+:4], cin=carry.
  - Each edge: acc[4·idx+:4]←s, carry←cout, idx←idx+1.
  - When idx=N-1 → DONE.
  - On that same edge, load `sum`←final acc, `cout`←RCA cout, `ovf`←(opA[MSB]==opB[MSB]) && (result[MSB]!=opA[MSB]).
- DONE: `done`=1 for exactly this cycle → IDLE unconditionally.
- `start` in RUN or DONE is ignored (not queued). A new request can be accepted in the IDLE cycle following DONE.
- Outputs `sum`/`cout`/`ovf` change only on the RUN→DONE edge and during reset. Partial nibbles are never visible on `sum`.
- `busy`=1 exactly in RUN; `done`=1 exactly in DONE; both are decoded from state.
- Arithmetic wraps modulo 2^WIDTH. `ovf` uses the inverted B for subtraction, which is correct for two's complement.

## Timing
- Reset (`rst_n`=0, asynchronous): state=IDLE, idx=0, carry=0, acc=0, `sum`=0, `cout`=0, `ovf`=0, `busy`=0, `done`=0.
- Reset mid-RUN or mid-DONE: abort immediately, with no partial result and no `done`. Operation resumes normally after release.
- `start` sampled at edge k:
  - `busy`=1 in cycles k+1 … k+N.
  - `done`=1 in cycle k+N+1.
  - Latency is N+1 cycles (5 for WIDTH=16).
- Throughput: one operation per N+2 cycles at most.
- Nibble path: the `RCA` is purely combinational between registers, with one ripple per cycle.

## Structure
- Package `rca_seq_pkg`: `state_t` enum {IDLE, RUN, DONE}, `localparam NIBBLE_W = 4`.
- Sub-module: exactly one instance of the existing `RCA` (ports `A`, `B`, `cin`, `s`, `cout`). No other adder logic is allowed in this block.
- idx counter width: $clog2(N), minimum 1.

## Test plan
- Add: WIDTH=16, a=0x0002, b=0x0003, cin=0, sub=0 → sum=0x0005, cout=0, ovf=0; `done` 5 cycles after `start`; `busy` high for exactly 4 cycles.
- Inter-nibble ripple: a=0x00FF, b=0x0001 → sum=0x0100, cout=0. Then a=0xFFFF, b=0x0001 → sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1, cout=0. Then a=0x8000, b=0xFFFF → sum=0x7FFF, ovf=1, cout=1.
- Subtract: a=0x0002, b=0x0005, sub=1, cin=1 (must be ignored) → sum=0xFFFD, cout=0, ovf=0. Then a=0x0005, b=0x0002 → sum=0x0003, cout=1.
- Start while busy: pulse `start` with new operands in the second RUN cycle → ignored; the original result completes and exactly one `done` pulse is seen. Prior `sum` stays stable until RUN→DONE.
- Reset mid-op: assert `rst_n`=0 asynchronously in the third RUN cycle → `busy`, `done`, `sum`, `cout`, `ovf` all 0 before the next edge, with no `done`. After release, 0x1234+0x1111 → sum=0x2345.

Source files
------------

// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor controller.
package rca_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/RCA.sv
// Existing 4-bit ripple-carry adder: purely combinational, s = A + B + cin.
module RCA (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  always_comb begin
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = A[i] ^ B[i] ^ c;
      c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Wide add/subtract built from one 4-bit RCA, processing one nibble per clock
// from LSB to MSB with the carry held in a register between cycles.
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N     = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  if ((WIDTH == 0) || (WIDTH % NIBBLE_W != 0)) begin : g_width_check
    $error("rca_seq_ctrl: WIDTH must be a non-zero multiple of 4");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] nib_a, nib_b, rca_s;
  logic                rca_cout;
  logic [WIDTH-1:0]    acc_upd;

  RCA u_rca (
    .A   (nib_a),
    .B   (nib_b),
    .cin (carry_q),
    .s   (rca_s),
    .cout(rca_cout)
  );

  // Nibble select and accumulator merge as explicit muxes keyed on idx.
  always_comb begin
    nib_a   = '0;
    nib_b   = '0;
    acc_upd = acc_q;
    for (int i = 0; i < int'(N); i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a = op_a_q[i*NIBBLE_W +: NIBBLE_W];
        nib_b = op_b_q[i*NIBBLE_W +: NIBBLE_W];
        acc_upd[i*NIBBLE_W +: NIBBLE_W] = rca_s;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_upd;
        carry_d = rca_cout;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = DONE;
          sum_d   = acc_upd;
          cout_d  = rca_cout;
          // B is already inverted for subtraction, so one rule covers both ops.
          ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                    (acc_upd[WIDTH-1] != op_a_q[WIDTH-1]);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Scoreboard bench for rca_seq_ctrl (WIDTH=16): stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_rca_seq_ctrl;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  rca_seq_ctrl #(.WIDTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(e.sum));
        chk("cout", 32'(cout), 32'(e.cout));
        chk("ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                       input logic tc);
    @(posedge clk);
    #1;
    a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                       input logic tc, input logic [15:0] es, input logic ec,
                       input logic eo);
    int busy_cnt, done_at;
    exp_q.push_back('{sum: es, cout: ec, ovf: eo});
    issue(ta, tb_v, ts, tc);
    busy_cnt = 0;
    done_at = 0;
    for (int c = 1; c <= 12 && done_at == 0; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_at = c;
    end
    chk("done_latency", 32'(done_at), 32'd5);
    chk("busy_cycles", 32'(busy_cnt), 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int done_cnt;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_op(16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0);
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op(16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    do_op(16'h0002, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
    do_op(16'h0005, 16'h0002, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0);

    // Start while busy: second request in RUN must be dropped.
    exp_q.push_back('{sum: 16'h0030, cout: 1'b0, ovf: 1'b0});
    issue(16'h0010, 16'h0020, 1'b0, 1'b0);
    @(negedge clk);
    chk("busy_run1", 32'(busy), 32'd1);
    chk("sum_hold_run1", 32'(sum), 32'h0003);
    @(posedge clk);
    #1;
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("sum_hold_run2", 32'(sum), 32'h0003);
    @(posedge clk);
    #1;
    start = 1'b0;
    done_cnt = 0;
    for (int c = 3; c <= 14; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) chk("sum_hold_busy", 32'(sum), 32'h0003);
    end
    chk("single_done", 32'(done_cnt), 32'd1);

    // Reset in the third RUN cycle aborts with no result.
    issue(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("abort_quiet", 32'(done_cnt), 32'd0);

    do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
